// File: rtl/note_scroller_pkg.sv
// Shared geometry and lane constants for the falling-square engine.
// Also holds the free-slot priority encoder used per lane.
package note_scroller_pkg;

  localparam int NUM_LANES = 4;
  localparam int SLOTS     = 6;
  localparam int NSLOT     = NUM_LANES * SLOTS;
  localparam int Y_W       = 10;
  localparam int SCREEN_H  = 480;
  localparam int HIT_TOP   = 400;
  localparam int HIT_BOT   = 440;

  // One-hot of the lowest-index empty slot; zero when the lane is full.
  function automatic logic [SLOTS-1:0] first_free(
    input logic [SLOTS-1:0] valid
  );
    logic [SLOTS-1:0] g;
    g = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/note_scroller_slot.sv
// One square slot: owns valid/y and applies the remove/move/spawn priority.
// Hit and miss flags are a pure decode of the registered state.
module note_slot
  import note_scroller_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           tick,
  input  logic           spawn,
  input  logic           remove,
  input  logic [7:0]     speed,
  output logic           valid,
  output logic [Y_W-1:0] y,
  output logic           hit,
  output logic           miss
);

  logic [Y_W:0] sum;

  always_comb begin
    sum  = (Y_W+1)'(y) + (Y_W+1)'(speed);
    hit  = valid && (y >= Y_W'(HIT_TOP)) && (y < Y_W'(HIT_BOT));
    miss = valid && (y >= Y_W'(HIT_BOT)) && (y < Y_W'(SCREEN_H));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      y     <= '0;
    end else if (run) begin
      if (remove && hit) begin
        valid <= 1'b0;
        y     <= '0;
      end else if (tick && valid) begin
        if (sum >= (Y_W+1)'(SCREEN_H)) begin
          valid <= 1'b0;
          y     <= '0;
        end else begin
          y <= sum[Y_W-1:0];
        end
      end else if (spawn) begin
        valid <= 1'b1;
        y     <= '0;
      end
    end
  end

endmodule

// File: rtl/note_scroller.sv
// Falling-square engine: frame tick divider, per-lane spawn allocation,
// drop reporting and packing of per-slot state for the renderer.
module note_scroller
  import note_scroller_pkg::*;
#(
  parameter int TICK_DIV = 1666667
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [NUM_LANES-1:0] column,
  input  logic [7:0]           speed,
  input  logic [NSLOT-1:0]     remove,
  output logic [2*NSLOT-1:0]   square_locations,
  output logic [NSLOT-1:0]     square_valid,
  output logic [NSLOT*Y_W-1:0] square_y,
  output logic                 spawn_drop
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]     cnt;
  logic                 tick;
  logic [NSLOT-1:0]     spawn;
  logic [NUM_LANES-1:0] full;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

  // Allocation looks only at start-of-cycle validity, so a slot freed
  // this cycle cannot be claimed until the next one.
  always_comb begin
    spawn = '0;
    full  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      full[l] = &square_valid[l*SLOTS +: SLOTS];
      if (column[l]) begin
        spawn[l*SLOTS +: SLOTS] = first_free(square_valid[l*SLOTS +: SLOTS]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spawn_drop <= 1'b0;
    end else begin
      spawn_drop <= run && |(column & full);
    end
  end

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    note_slot u_slot (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .tick   (tick),
      .spawn  (spawn[k]),
      .remove (remove[k]),
      .speed  (speed),
      .valid  (square_valid[k]),
      .y      (square_y[k*Y_W +: Y_W]),
      .hit    (square_locations[2*k]),
      .miss   (square_locations[2*k+1])
    );
  end

endmodule

// File: tb/tb_note_scroller.sv
// Directed bench for note_scroller with a 4-cycle frame tick.
// Tick timing comes from a small reference counter kept in the bench.
module tb_note_scroller;
  import note_scroller_pkg::*;

  localparam int TD = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 run;
  logic [NUM_LANES-1:0] column;
  logic [7:0]           speed;
  logic [NSLOT-1:0]     remove;
  logic [2*NSLOT-1:0]   square_locations;
  logic [NSLOT-1:0]     square_valid;
  logic [NSLOT*Y_W-1:0] square_y;
  logic                 spawn_drop;

  int n_cmp = 0;
  int n_err = 0;
  int ref_cnt = 0;

  always #5 clk = ~clk;

  note_scroller #(.TICK_DIV(TD)) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .column           (column),
    .speed            (speed),
    .remove           (remove),
    .square_locations (square_locations),
    .square_valid     (square_valid),
    .square_y         (square_y),
    .spawn_drop       (spawn_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; bench tick reference advances like a 0..TD-1 counter.
  task automatic step(output bit was_tick);
    @(posedge clk);
    was_tick = run && !rst && (ref_cnt == TD - 1);
    if (rst) ref_cnt = 0;
    else if (run) ref_cnt = (ref_cnt == TD - 1) ? 0 : ref_cnt + 1;
    #1;
  endtask

  task automatic cyc(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(t);
  endtask

  task automatic wait_ticks(input int n);
    bit t;
    int seen;
    seen = 0;
    for (int i = 0; i < n * TD + 8 && seen < n; i++) begin
      step(t);
      if (t) seen++;
    end
    chk("tick_budget", 64'(seen), 64'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_LANES-1:0] c);
    column = c;
    cyc(1);
    column = '0;
  endtask

  function automatic logic [Y_W-1:0] ys(input int k);
    return square_y[k*Y_W +: Y_W];
  endfunction

  initial begin
    rst = 1'b1;
    run = 1'b1;
    column = '0;
    speed = 8'd40;
    remove = '0;

    // 1: reset, spawn, fall through hit and miss zones, off-screen
    do_reset();
    chk("rst_loc", 64'(square_locations), 64'd0);
    chk("rst_valid", 64'(square_valid), 64'd0);
    chk("rst_y", 64'(square_y[63:0]), 64'd0);
    chk("rst_drop", 64'(spawn_drop), 64'd0);
    pulse(4'b0001);
    chk("spawn_v0", 64'(square_valid), 64'd1);
    chk("spawn_y0", 64'(ys(0)), 64'd0);
    wait_ticks(10);
    chk("t10_y", 64'(ys(0)), 64'd400);
    chk("t10_loc", 64'(square_locations[1:0]), 64'b01);
    wait_ticks(1);
    chk("t11_y", 64'(ys(0)), 64'd440);
    chk("t11_loc", 64'(square_locations[1:0]), 64'b10);
    wait_ticks(1);
    chk("t12_loc", 64'(square_locations[1:0]), 64'b00);
    chk("t12_valid", 64'(square_valid), 64'd0);
    chk("t12_y", 64'(ys(0)), 64'd0);

    // 2: hit removal with held remove
    pulse(4'b0001);
    wait_ticks(10);
    chk("pre_rm_y", 64'(ys(0)), 64'd400);
    remove[0] = 1'b1;
    cyc(1);
    chk("rm_valid", 64'(square_valid[0]), 64'd0);
    chk("rm_loc", 64'(square_locations[1:0]), 64'b00);
    cyc(2);
    remove[0] = 1'b0;
    chk("rm_hold_v", 64'(square_valid[0]), 64'd0);
    chk("rm_hold_loc", 64'(square_locations[1:0]), 64'b00);

    // 3: remove outside hit zone ignored
    do_reset();
    pulse(4'b0001);
    wait_ticks(3);
    chk("y120", 64'(ys(0)), 64'd120);
    remove[0] = 1'b1;
    cyc(1);
    chk("rm_ign_v", 64'(square_valid[0]), 64'd1);
    chk("rm_ign_y", 64'(ys(0)), 64'd120);
    wait_ticks(1);
    remove[0] = 1'b0;
    chk("rm_ign_y160", 64'(ys(0)), 64'd160);

    // 4: fill lane 3, seventh spawn dropped
    do_reset();
    speed = 8'd0;
    for (int i = 0; i < 6; i++) pulse(4'b1000);
    chk("l3_valid", 64'(square_valid), 64'h00FC_0000);
    chk("l3_drop0", 64'(spawn_drop), 64'd0);
    pulse(4'b1000);
    chk("l3_drop1", 64'(spawn_drop), 64'd1);
    chk("l3_valid2", 64'(square_valid), 64'h00FC_0000);
    chk("l3_y23", 64'(ys(23)), 64'd0);
    cyc(1);
    chk("l3_drop_end", 64'(spawn_drop), 64'd0);

    // 5: freed slot not reusable in same cycle
    do_reset();
    speed = 8'd0;
    for (int i = 0; i < 3; i++) pulse(4'b0001);
    speed = 8'd40;
    wait_ticks(10);
    speed = 8'd0;
    for (int i = 0; i < 3; i++) pulse(4'b0001);
    chk("l0_full", 64'(square_valid), 64'h3F);
    chk("l0_y2", 64'(ys(2)), 64'd400);
    remove[2] = 1'b1;
    column = 4'b0001;
    cyc(1);
    remove[2] = 1'b0;
    chk("same_cyc_v", 64'(square_valid), 64'h3B);
    chk("same_cyc_drop", 64'(spawn_drop), 64'd1);
    cyc(1);
    column = '0;
    chk("reuse_v", 64'(square_valid), 64'h3F);
    chk("reuse_y2", 64'(ys(2)), 64'd0);
    chk("reuse_drop", 64'(spawn_drop), 64'd0);

    // 6: freeze with run = 0, then reset while frozen
    do_reset();
    speed = 8'd40;
    pulse(4'b0001);
    wait_ticks(2);
    cyc(1);
    chk("pre_frz_y", 64'(ys(0)), 64'd80);
    run = 1'b0;
    column = 4'b0010;
    cyc(20);
    column = '0;
    chk("frz_y", 64'(ys(0)), 64'd80);
    chk("frz_valid", 64'(square_valid), 64'd1);
    run = 1'b1;
    cyc(2);
    chk("frz_cnt_a", 64'(ys(0)), 64'd80);
    cyc(1);
    chk("frz_cnt_b", 64'(ys(0)), 64'd120);
    run = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("frz_rst_v", 64'(square_valid), 64'd0);
    chk("frz_rst_y", 64'(ys(0)), 64'd0);
    chk("frz_rst_loc", 64'(square_locations), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
